// File: rtl/fifo_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader_pkg
// Function : Shared types and constants for the FIFO-to-stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_stream_reader_pkg;

  // Number of words held by the reader's output buffer.
  localparam logic [1:0] BUF_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Function : Two-entry in-order word buffer; head entry drives the stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [1:0]       o_count,
  output logic [WIDTH-1:0] o_head
);

  buf_state_t       r_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_wr) begin
            r_head  <= i_wdata;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (i_wr && i_rd) begin
            r_head <= i_wdata;
          end else if (i_wr) begin
            r_tail  <= i_wdata;
            r_state <= TWO;
          end else if (i_rd) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          // Upstream control never captures into a full buffer without a read.
          if (i_rd) begin
            r_head <= r_tail;
            if (i_wr) begin
              r_tail <= i_wdata;
            end else begin
              r_state <= ONE;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_count = r_state;
  assign o_head  = r_head;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Function : Pops a registered-output FIFO and presents words as a stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [31:0]      xfer_count,
  output logic             busy
);

  logic        r_inflight;
  logic [31:0] r_xfer_count;
  logic [1:0]  w_count;
  logic        w_hs;
  logic        w_capture;
  logic [2:0]  w_pending;

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_wr    (w_capture),
    .i_wdata (fifo_dout),
    .i_rd    (w_hs),
    .o_count (w_count),
    .o_head  (m_data)
  );

  assign occupancy = w_count;
  assign m_valid   = (w_count != 2'd0);
  assign w_hs      = m_valid && m_ready;
  assign w_capture = r_inflight && !flush;

  // Words committed after this edge: buffered plus in flight, minus the one leaving.
  assign w_pending = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_hs};
  assign fifo_pop  = !fifo_empty && !flush && rst_n && (w_pending < {1'b0, BUF_DEPTH});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight   <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_inflight <= fifo_pop;
      if (w_hs) begin
        r_xfer_count <= r_xfer_count + 32'd1;
      end
    end
  end

  assign xfer_count = r_xfer_count;
  assign busy       = m_valid || r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Function : Self-checking bench with an upstream FIFO model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int WIDTH = 8;
  localparam int TMO   = 60;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_dout  = '0;
  logic             m_valid;
  logic             m_ready    = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             flush      = 1'b0;
  logic [1:0]       occupancy;
  logic [31:0]      xfer_count;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] owed[$];
  logic [31:0]      exp_xfer  = '0;
  logic             last_pop  = 1'b0;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;
  logic             mon_en    = 1'b0;

  int               occ_model;
  logic             hs_s;
  logic             exp_pop;
  logic             exp_busy;
  logic [WIDTH-1:0] want;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .flush      (flush),
    .occupancy  (occupancy),
    .xfer_count (xfer_count),
    .busy       (busy)
  );

  // Upstream FIFO model plus a scoreboard of words owed to the stream side.
  always @(posedge clk) begin
    occ_model = owed.size() - (last_pop ? 1 : 0);
    hs_s      = (m_valid === 1'b1) && (m_ready === 1'b1);
    exp_pop   = (fifo_empty === 1'b0) && !flush && rst_n &&
                ((occ_model + (last_pop ? 1 : 0) - (hs_s ? 1 : 0)) < 2);
    exp_busy  = (occ_model != 0) || last_pop;
    if (mon_en) begin
      checks++;
      if (occupancy !== 2'(occ_model) || m_valid !== (occ_model != 0)) begin
        failures++;
        $display("FAIL mon_occupancy got occ=%0d valid=%b required occ=%0d", occupancy, m_valid, occ_model);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL mon_busy got=%b required=%b", busy, exp_busy);
      end
      checks++;
      if (xfer_count !== exp_xfer) begin
        failures++;
        $display("FAIL mon_xfer_count got=%h required=%h", xfer_count, exp_xfer);
      end
      checks++;
      if (fifo_pop !== exp_pop) begin
        failures++;
        $display("FAIL mon_fifo_pop got=%b required=%b", fifo_pop, exp_pop);
      end
      if (hold_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== hold_data) begin
          failures++;
          $display("FAIL mon_stable got valid=%b data=%h required valid=1 data=%h", m_valid, m_data, hold_data);
        end
      end
    end
    if (hs_s) begin
      checks++;
      if (owed.size() == 0) begin
        failures++;
        $display("FAIL sb_extra_word got=%h required=<none>", m_data);
      end else begin
        want = owed.pop_front();
        if (m_data !== want) begin
          failures++;
          $display("FAIL sb_order got=%h required=%h", m_data, want);
        end
      end
      exp_xfer = exp_xfer + 32'd1;
    end
    if (!rst_n) exp_xfer = '0;
    if (!rst_n || flush) owed.delete();
    if (fifo_pop === 1'b1) begin
      checks++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL pop_on_empty got=pop required=no_pop");
      end else begin
        owed.push_back(fq[0]);
        fifo_dout <= fq.pop_front();
      end
    end
    last_pop   = (fifo_pop === 1'b1);
    fifo_empty <= (fq.size() == 0);
    hold_prev  = mon_en && (m_valid === 1'b1) && (m_ready !== 1'b1) && !flush && rst_n;
    hold_data  = m_data;
  end

  task automatic test_reset();
    m_ready = 1'b1;
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (fifo_pop !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_pop got=%b required=0", fifo_pop);
      end
    end
    checks++;
    if (occupancy !== 2'd0 || m_valid !== 1'b0 || m_data !== '0 || xfer_count !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got occ=%0d valid=%b data=%h xfer=%h busy=%b required all zero",
               occupancy, m_valid, m_data, xfer_count, busy);
    end
    fq.delete();
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    rst_n  = 1'b1;
  endtask

  task automatic test_single();
    bit seen = 0;
    m_ready = 1'b1;
    fq.push_back(8'hA5);
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk);
      if (fifo_pop === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL single_pop got=no_pop required=pop");
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || fifo_pop !== 1'b0) begin
      failures++;
      $display("FAIL single_n1 got valid=%b pop=%b required valid=0 pop=0", m_valid, fifo_pop);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_n2 got valid=%b data=%h required valid=1 data=a5", m_valid, m_data);
    end
    @(negedge clk);
    checks++;
    if (xfer_count !== 32'd1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after got xfer=%0d busy=%b valid=%b required xfer=1 busy=0 valid=0",
               xfer_count, busy, m_valid);
    end
  endtask

  task automatic test_stream();
    bit          seen = 0;
    logic [31:0] base;
    base    = exp_xfer;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) fq.push_back(WIDTH'(i));
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stream_start got=no_valid required=valid");
    end
    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== WIDTH'(k)) begin
        failures++;
        $display("FAIL stream_word%0d got valid=%b data=%h required valid=1 data=%h", k, m_valid, m_data, WIDTH'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (xfer_count !== base + 32'd16 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_count got xfer=%0d valid=%b required xfer=%0d valid=0", xfer_count, m_valid, base + 32'd16);
    end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    int idx  = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(WIDTH'(i));
    repeat (10) begin
      @(negedge clk);
      if (fifo_pop === 1'b1) pops++;
    end
    checks++;
    if (pops != 2) begin
      failures++;
      $display("FAIL bp_pops got=%0d required=2", pops);
    end
    checks++;
    if (occupancy !== 2'd2 || m_valid !== 1'b1 || m_data !== 8'h00) begin
      failures++;
      $display("FAIL bp_full got occ=%0d valid=%b data=%h required occ=2 valid=1 data=00", occupancy, m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int t = 0; t < TMO && idx < 4; t++) begin
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== WIDTH'(idx)) begin
          failures++;
          $display("FAIL bp_order got=%h required=%h", m_data, WIDTH'(idx));
        end
        idx++;
      end
      @(negedge clk);
    end
    checks++;
    if (idx != 4) begin
      failures++;
      $display("FAIL bp_drain got=%0d required=4", idx);
    end
  endtask

  task automatic test_flush();
    bit          seen = 0;
    logic [31:0] base;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back(8'h40 + WIDTH'(i));
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk);
      if (occupancy === 2'd2) seen = 1;
    end
    base  = exp_xfer;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0 || busy !== 1'b0 || xfer_count !== base) begin
      failures++;
      $display("FAIL flush_clear got valid=%b occ=%0d busy=%b xfer=%0d required 0 0 0 %0d",
               m_valid, occupancy, busy, xfer_count, base);
    end
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1;
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h42) begin
      failures++;
      $display("FAIL flush_next got valid=%b data=%h required valid=1 data=42", m_valid, m_data);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_wrap_reset();
    bit seen = 0;
    m_ready = 1'b0;
    @(negedge clk);
    force dut.r_xfer_count = 32'hFFFF_FFFF;
    exp_xfer = 32'hFFFF_FFFF;
    #1 release dut.r_xfer_count;
    @(negedge clk);
    checks++;
    if (xfer_count !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_preset got=%h required=ffffffff", xfer_count);
    end
    m_ready = 1'b1;
    fq.push_back(8'h5A);
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1;
    end
    @(negedge clk);
    checks++;
    if (xfer_count !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_zero got=%h required=00000000", xfer_count);
    end
    m_ready = 1'b0;
    fq.push_back(8'h77);
    fq.push_back(8'h78);
    seen = 0;
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk);
      if (occupancy === 2'd1) seen = 1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd0 || m_valid !== 1'b0 || m_data !== '0 || xfer_count !== 32'd0 ||
        busy !== 1'b0 || fifo_pop !== 1'b0) begin
      failures++;
      $display("FAIL midreset got occ=%0d valid=%b data=%h xfer=%h busy=%b pop=%b required all zero",
               occupancy, m_valid, m_data, xfer_count, busy, fifo_pop);
    end
    rst_n   = 1'b1;
    m_ready = 1'b1;
    fq.push_back(8'h79);
    seen = 0;
    for (int i = 0; i < TMO && !seen; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen = 1;
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h79) begin
      failures++;
      $display("FAIL post_reset_word got valid=%b data=%h required valid=1 data=79", m_valid, m_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random_traffic();
    bit drained = 0;
    repeat (600) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0 && fq.size() < 20) begin
        repeat ($urandom_range(1, 3)) fq.push_back(WIDTH'($urandom));
      end
      m_ready = ($urandom_range(0, 99) < 60);
      flush   = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    flush   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && !drained; i++) begin
      @(negedge clk);
      if (fq.size() == 0 && owed.size() == 0 && busy === 1'b0) drained = 1;
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL random_drain got fifo=%0d owed=%0d busy=%b required 0 0 0", fq.size(), owed.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap_reset();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
